// File: rtl/bce_pkg.sv
// bce_pkg: branch function codes, sequencer states and code classification helpers
// shared by the branch condition evaluator and the PC sequencer.
package bce_pkg;

    localparam logic [3:0] BF_BLTZ  = 4'b0010;
    localparam logic [3:0] BF_BGEZ  = 4'b0011;
    localparam logic [3:0] BF_BEQ   = 4'b1000;
    localparam logic [3:0] BF_BEQL  = 4'b1001;
    localparam logic [3:0] BF_BNE   = 4'b1010;
    localparam logic [3:0] BF_BNEL  = 4'b1011;
    localparam logic [3:0] BF_BLEZ  = 4'b1100;
    localparam logic [3:0] BF_BLEZL = 4'b1101;
    localparam logic [3:0] BF_BGTZ  = 4'b1110;
    localparam logic [3:0] BF_BGTZL = 4'b1111;

    typedef enum logic {BOOT, RUN} state_e;

    // Legal set is 0010, 0011 and the whole 1xxx range.
    function automatic logic is_legal_bf(input logic [3:0] bf);
        return bf[3] | (bf[3:1] == 3'b001);
    endfunction

    function automatic logic is_likely(input logic [3:0] bf);
        return bf[3] & bf[0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i & ~&cnt_q) ? cnt_q + {{(W-1){1'b0}}, 1'b1} : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC sequencer fed by the branch condition unit; issues
// redirects, delay-slot kill/annul strobes and branch statistics.
module branch_pc_unit
    import bce_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0180,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             exc_i,
    input  logic             br_valid_i,
    input  logic [3:0]       bf_i,
    input  logic             bcres_i,
    input  logic [31:0]      br_target_i,
    input  logic             jmp_valid_i,
    input  logic [31:0]      jmp_target_i,
    input  logic             cnt_clr_i,
    output logic [31:0]      pc_o,
    output logic             pc_valid_o,
    output logic             kill_id_o,
    output logic             annul_ex_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] tk_cnt_o,
    output logic             bad_op_o
);

    state_e      state_q;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q;
    logic        kill_q, kill_d;
    logic        annul_q, annul_d;
    logic        bad_op_q;

    logic run, take, likely_nt, cnt_en, bad_set;

    assign run       = (state_q == RUN);
    assign take      = br_valid_i & bcres_i;
    assign likely_nt = br_valid_i & is_likely(bf_i) & ~bcres_i;
    assign cnt_en    = run & br_valid_i & ~stall_i & ~exc_i;
    assign bad_set   = run & ~stall_i & br_valid_i & (~is_legal_bf(bf_i) | jmp_valid_i);

    // Redirect priority: exception, stall, jump, taken branch, sequential.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        kill_d  = 1'b0;
        annul_d = 1'b0;
        if (exc_i) begin
            pc_d    = EXC_VECTOR;
            kill_d  = 1'b1;
            annul_d = 1'b1;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (jmp_valid_i) begin
            pc_d   = jmp_target_i;
            kill_d = 1'b1;
        end else if (take) begin
            pc_d   = br_target_i;
            kill_d = 1'b1;
        end else begin
            annul_d = likely_nt;
        end
    end

    // BOOT spends one cycle presenting RESET_PC as invalid, then fetches it for real.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            kill_q     <= 1'b0;
            annul_q    <= 1'b0;
            bad_op_q   <= 1'b0;
        end else if (state_q == BOOT) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
            kill_q     <= 1'b0;
            annul_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            annul_q  <= annul_d;
            bad_op_q <= bad_op_q | bad_set;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (cnt_en),
        .cnt_o (br_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_tk_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (cnt_en & take),
        .cnt_o (tk_cnt_o)
    );

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign kill_id_o  = kill_q;
    assign annul_ex_o = annul_q;
    assign bad_op_o   = bad_op_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed and random stimulus against a cycle-level reference
// model; a second instance with 2-bit counters exercises saturation.
module tb_branch_pc_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0180;

    logic        clk = 1'b0;
    logic        rst, stall, exc, br_valid, bcres, jmp_valid, cnt_clr;
    logic [3:0]  bf;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc, pc2;
    logic        pc_valid, kill_id, annul_ex, bad_op;
    logic        pc_valid2, kill_id2, annul_ex2, bad_op2;
    logic [15:0] br_cnt, tk_cnt;
    logic [1:0]  br_cnt2, tk_cnt2;

    int checks = 0;
    int errors = 0;

    bit          m_boot, m_valid, m_kill, m_annul, m_bad;
    logic [31:0] m_pc;
    int          m_br, m_tk, m_br2, m_tk2;

    always #5 clk = ~clk;

    branch_pc_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall), .exc_i(exc), .br_valid_i(br_valid),
        .bf_i(bf), .bcres_i(bcres), .br_target_i(br_target), .jmp_valid_i(jmp_valid),
        .jmp_target_i(jmp_target), .cnt_clr_i(cnt_clr), .pc_o(pc), .pc_valid_o(pc_valid),
        .kill_id_o(kill_id), .annul_ex_o(annul_ex), .br_cnt_o(br_cnt), .tk_cnt_o(tk_cnt),
        .bad_op_o(bad_op)
    );

    branch_pc_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall), .exc_i(exc), .br_valid_i(br_valid),
        .bf_i(bf), .bcres_i(bcres), .br_target_i(br_target), .jmp_valid_i(jmp_valid),
        .jmp_target_i(jmp_target), .cnt_clr_i(cnt_clr), .pc_o(pc2), .pc_valid_o(pc_valid2),
        .kill_id_o(kill_id2), .annul_ex_o(annul_ex2), .br_cnt_o(br_cnt2), .tk_cnt_o(tk_cnt2),
        .bad_op_o(bad_op2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] b);
        return b == 4'd2 || b == 4'd3 || b >= 4'd8;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return v < max ? v + 1 : max;
    endfunction

    // One clock of architectural behaviour, evaluated from the inputs present at the edge.
    task automatic model_step();
        bit counted;
        if (rst) begin
            m_boot = 1; m_pc = RST_PC; m_valid = 0; m_kill = 0; m_annul = 0; m_bad = 0;
            m_br = 0; m_tk = 0; m_br2 = 0; m_tk2 = 0;
            return;
        end
        counted = !m_boot && br_valid && !stall && !exc;
        if (cnt_clr) begin
            m_br = 0; m_tk = 0; m_br2 = 0; m_tk2 = 0;
        end else if (counted) begin
            m_br = sat_inc(m_br, 65535);
            m_br2 = sat_inc(m_br2, 3);
            if (bcres) begin
                m_tk = sat_inc(m_tk, 65535);
                m_tk2 = sat_inc(m_tk2, 3);
            end
        end
        if (m_boot) begin
            m_boot = 0; m_valid = 1; m_kill = 0; m_annul = 0;
            return;
        end
        if (!stall && br_valid && (!legal(bf) || jmp_valid)) m_bad = 1;
        m_kill = 0;
        m_annul = 0;
        if (exc) begin
            m_pc = EXC_PC; m_kill = 1; m_annul = 1;
        end else if (stall) begin
        end else if (jmp_valid) begin
            m_pc = jmp_target; m_kill = 1;
        end else if (br_valid && bcres) begin
            m_pc = br_target; m_kill = 1;
        end else begin
            m_pc = m_pc + 32'd4;
            m_annul = br_valid && bf >= 4'd8 && bf[0] && !bcres;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("pc_valid", 32'(pc_valid), 32'(m_valid));
        check("kill_id", 32'(kill_id), 32'(m_kill));
        check("annul_ex", 32'(annul_ex), 32'(m_annul));
        check("br_cnt", 32'(br_cnt), m_br);
        check("tk_cnt", 32'(tk_cnt), m_tk);
        check("bad_op", 32'(bad_op), 32'(m_bad));
        check("br_cnt_w2", 32'(br_cnt2), m_br2);
        check("tk_cnt_w2", 32'(tk_cnt2), m_tk2);
    endtask

    task automatic idle();
        rst = 0; stall = 0; exc = 0; br_valid = 0; bf = 4'd0; bcres = 0;
        br_target = 32'd0; jmp_valid = 0; jmp_target = 32'd0; cnt_clr = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        check("rst_pc", pc, RST_PC);
        check("rst_valid", 32'(pc_valid), 32'd0);
        rst = 0;
        tick();
        check("boot_pc", pc, RST_PC);
        check("boot_valid", 32'(pc_valid), 32'd1);
        tick();
        check("seq_pc1", pc, 32'hBFC0_0004);
        tick();
        check("seq_pc2", pc, 32'hBFC0_0008);

        br_valid = 1; bf = 4'b1000; bcres = 1; br_target = 32'h0040_0100;
        tick();
        check("beq_pc", pc, 32'h0040_0100);
        check("beq_kill", 32'(kill_id), 32'd1);
        check("beq_tk", 32'(tk_cnt), 32'd1);
        idle();
        tick();
        check("beq_kill_drop", 32'(kill_id), 32'd0);

        jmp_valid = 1; jmp_target = 32'h0000_1000;
        tick();
        idle();
        br_valid = 1; bf = 4'b1011; bcres = 0;
        tick();
        check("bnel_pc", pc, 32'h0000_1004);
        check("bnel_annul", 32'(annul_ex), 32'd1);
        check("bnel_kill", 32'(kill_id), 32'd0);
        check("bnel_tk", 32'(tk_cnt), 32'd1);

        idle();
        stall = 1; br_valid = 1; bf = 4'b1000; bcres = 1; br_target = 32'h0000_2000;
        repeat (3) begin
            tick();
            check("stall_pc", pc, 32'h0000_1004);
            check("stall_br", 32'(br_cnt), 32'd2);
        end
        stall = 0;
        tick();
        check("unstall_pc", pc, 32'h0000_2000);
        check("unstall_br", 32'(br_cnt), 32'd3);

        idle();
        exc = 1; stall = 1; jmp_valid = 1; jmp_target = 32'h1234_5678;
        tick();
        check("exc_pc", pc, EXC_PC);
        check("exc_annul", 32'(annul_ex), 32'd1);

        idle();
        jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        check("wrap_pc", pc, 32'h0000_0000);

        br_valid = 1; bf = 4'b0101; bcres = 0;
        tick();
        check("illegal_bad", 32'(bad_op), 32'd1);
        idle();
        repeat (3) tick();
        check("bad_sticky", 32'(bad_op), 32'd1);

        br_valid = 1; bf = 4'b1110; bcres = 1; br_target = 32'h0000_3000;
        repeat (5) tick();
        check("sat_tk_w2", 32'(tk_cnt2), 32'd3);
        check("tk_w16", 32'(tk_cnt), 32'd7);
        cnt_clr = 1;
        tick();
        check("clr_br", 32'(br_cnt), 32'd0);
        check("clr_tk", 32'(tk_cnt), 32'd0);

        idle();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(199) == 0);
            stall      = ($urandom_range(4) == 0);
            exc        = ($urandom_range(19) == 0);
            br_valid   = ($urandom_range(9) < 4);
            bf         = ($urandom_range(9) == 0) ? 4'($urandom) : {1'b1, 3'($urandom)};
            bcres      = legal(bf) ? 1'($urandom) : 1'b0;
            br_target  = $urandom;
            jmp_valid  = ($urandom_range(6) == 0);
            jmp_target = $urandom;
            cnt_clr    = ($urandom_range(39) == 0);
            tick();
        end

        idle();
        rst = 1;
        tick();
        check("final_rst_bad", 32'(bad_op), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter sequencer that sits directly downstream of the branch condition evaluation unit. It consumes the unit's `bcres` decision and the branch function code for the branch currently in EX. It produces the fetch PC, pipeline kill/annul strobes, and branch statistics. The architecture has one delay slot: the branch resolves in EX while its delay slot is in ID and PC+8 is in IF.

## Interface
- `RESET_PC`, 32'hBFC0_0000, fetch address after reset
- `EXC_VECTOR`, 32'hBFC0_0180, exception redirect address
- `CNT_W`, 16, width of statistics counters

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  global pipeline freeze
- `exc`  in  1  exception request, overrides stall
- `br_valid`  in  1  conditional branch present in EX
- `bf`  in  4  branch function code of that branch
- `bcres`  in  1  branch condition result for that branch
- `br_target`  in  32  branch target address
- `jmp_valid`  in  1  unconditional jump present in EX
- `jmp_target`  in  32  jump target address
- `cnt_clr`  in  1  clear statistics counters
- `pc`  out  32  fetch address (registered)
- `pc_valid`  out  1  `pc` is a real fetch
- `kill_id`  out  1  instruction now in ID is squashed
- `annul_ex`  out  1  instruction now in EX (delay slot) is annulled
- `br_cnt`  out  CNT_W  resolved branches, saturating
- `tk_cnt`  out  CNT_W  taken branches, saturating
- `bad_op`  out  1  sticky illegal-event flag

## Operation
- **Legal `bf` codes:** 0010, 0011, 1000–1111.
- **Likely branch:** `bf[3] & bf[0]`.
- **Decisions:**
  - `take = br_valid & bcres`.
  - `likely_nt = br_valid & likely & ~bcres`.
- **FSM states:**
  - BOOT: entered on reset; `pc = RESET_PC`, `pc_valid = 0`. Advances to RUN after one cycle with `pc` unchanged.
  - RUN: normal operation.
  - There is no exit from RUN except reset.
- **Next-PC priority in RUN, highest first:**
  1. `exc`: `pc <= EXC_VECTOR`, `kill_id <= 1`, `annul_ex <= 1`.
  2. `stall`: all state holds, strobes 0. Branch and jump inputs are ignored because the pipeline re-presents them.
  3. `jmp_valid`: `pc <= jmp_target`, `kill_id <= 1`.
  4. `take`: `pc <= br_target`, `kill_id <= 1`.
  5. `likely_nt`: `pc <= pc + 4`, `kill_id <= 0`, `annul_ex <= 1`.
  6. Otherwise: `pc <= pc + 4`.
- **Arithmetic:** `pc + 4` is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- **Targets:** taken unchanged, including misaligned values. The fetch side is responsible for alignment faults.
- **Counters:** update only when `br_valid & ~stall & ~exc`.
  - `br_cnt` increments on every such branch.
  - `tk_cnt` increments when `take`.
  - Both saturate at all-ones.
  - `cnt_clr` zeroes both and wins over a same-cycle increment.
  - `cnt_clr` is honoured even under `stall`.
- **`bad_op`:** set on the edge after either of the following, when not stalled. Cleared only by `rst`.
  - `br_valid` with an illegal `bf`.
  - `br_valid & jmp_valid` together.
- **Simultaneous `br_valid & jmp_valid`:** the jump wins.
- **Illegal `bf`:** `bcres` is 0 for these codes, so the branch acts as not-taken and non-likely.

## Timing
- **Reset values:** `pc = RESET_PC`, `pc_valid = 0`, `kill_id = 0`, `annul_ex = 0`, counters 0, `bad_op = 0`.
- **Reset mid-operation:** any pending redirect or strobe is discarded; the next cycle is BOOT.
- **Redirect latency:** one cycle. Inputs sampled at edge t give a new `pc` and strobes visible after edge t.
- **Strobe width:**
  - `kill_id` and `annul_ex` are high for exactly one cycle per event.
  - They are never high during BOOT.
  - They drop to 0 on a stall cycle.
- **`pc_valid`:** 1 in every RUN cycle, including stalled ones, where `pc` is repeated.
- **Back-to-back redirects:** a redirect in consecutive cycles is legal. Each applies its own target, and `kill_id` stays high for both cycles.
- **`exc` during BOOT:** ignored.

## Structure
- **Shared package `bce_pkg`:**
  - 4-bit `bf` code constants: BLTZ=0010, BGEZ=0011, BEQ=1000, BNE=1010, BLEZ=1100, BGTZ=1110, and likely variants = code | 1.
  - FSM state enum {BOOT, RUN}.
  - `is_legal_bf` and `is_likely` functions.
- **Sub-module:** one, `sat_counter`, parameterised by width, with `clr` and `inc` inputs. It is instantiated twice for `br_cnt` and `tk_cnt`.

## Test plan
- **Reset release:** release `rst` → BOOT for one cycle with `pc = BFC00000`, `pc_valid = 0`; then BFC00004, BFC00008 with `pc_valid = 1`.
- **Taken BEQ:** `bf = 1000`, `bcres = 1`, `br_target = 00400100` → next `pc = 00400100`, `kill_id = 1` for one cycle, `br_cnt = tk_cnt = 1`.
- **BNE-likely not taken:** `bf = 1011`, `bcres = 0` at `pc = 00001000` → next `pc = 00001004`, `annul_ex = 1`, `kill_id = 0`, `tk_cnt` unchanged.
- **Stall with branch:** `stall = 1` with `br_valid`, `bcres = 1` for 3 cycles → `pc` holds, strobes 0, counters unchanged. Release `stall` → redirect taken once, `br_cnt += 1`.
- **Exception under stall, same cycle as a jump:** `exc = 1`, `stall = 1`, `jmp_valid = 1` → `pc = BFC00180`, `kill_id = annul_ex = 1`.
- **Illegal code and saturation:**
  - `bf = 0101` with `br_valid` → `bad_op = 1`, and it stays set until `rst`.
  - With `CNT_W = 2`, five taken branches → `tk_cnt = 3`.
  - `cnt_clr` on the same cycle as a branch → counters 0.
